// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants and helpers for the packed-BCD up/down counter.
// Both the digit cells and the load validator use this package.
package bcd_updown_counter_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_REJECT,
        ACT_STEP
    } action_t;

    function automatic logic is_bcd(input logic [BCD_W-1:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Bus bundle for the BCD counter: count controls, the load port and the registered status.
// The master side drives the controls, and the counter owns the slave side.
interface bcd_updown_counter_if #(parameter int DIGITS = 3);
    import bcd_updown_counter_pkg::*;

    logic                     en;
    logic                     up;
    logic                     load;
    logic [BCD_W*DIGITS-1:0]  load_val;
    logic [BCD_W*DIGITS-1:0]  count;
    logic                     ovf;
    logic                     unf;
    logic                     load_err;
    logic                     is_zero;

    modport master (
        output en, up, load, load_val,
        input  count, ovf, unf, load_err, is_zero
    );

    modport slave (
        input  en, up, load, load_val,
        output count, ovf, unf, load_err, is_zero
    );

endinterface

// File: rtl/bcd_updown_counter_digit.sv
// One decimal digit cell. It produces the stepped value of its nibble and flags when it sits
// at 9 or at 0, so the top level can build the carry and borrow chains.
module bcd_digit
    import bcd_updown_counter_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             step,
    input  logic             up,
    output logic [BCD_W-1:0] next_digit,
    output logic             at_max,
    output logic             at_min
);

    assign at_max = (digit == BCD_MAX);
    assign at_min = (digit == BCD_MIN);

    // A digit leaving 9 upward or 0 downward wraps inside the digit; the carry/borrow is external
    always_comb begin
        next_digit = digit;
        if (step) begin
            if (up)
                next_digit = at_max ? BCD_MIN : digit + 4'd1;
            else
                next_digit = at_min ? BCD_MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Registered multi-digit packed-BCD up/down counter with validated parallel load,
// wrap or saturate at the ends, and one-cycle overflow, underflow and load-error pulses.
module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter bit SATURATE = 1'b0
)
(
    input  logic                  clk,
    input  logic                  reset,
    bcd_updown_counter_if.slave   bus
);

    localparam int W = BCD_W * DIGITS;

    logic [W-1:0]      count_q;
    logic [W-1:0]      count_d;
    logic [W-1:0]      stepped;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS:0]   max_chain;
    logic [DIGITS:0]   min_chain;
    logic              load_ok;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              err_q, err_d;
    action_t           action;

    // Digit i steps only when every lower digit is at the rollover value for this direction
    assign max_chain[0] = 1'b1;
    assign min_chain[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .digit      (count_q[i*BCD_W +: BCD_W]),
            .step       (bus.up ? max_chain[i] : min_chain[i]),
            .up         (bus.up),
            .next_digit (stepped[i*BCD_W +: BCD_W]),
            .at_max     (at_max[i]),
            .at_min     (at_min[i])
        );
        assign max_chain[i+1] = max_chain[i] & at_max[i];
        assign min_chain[i+1] = min_chain[i] & at_min[i];
    end

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(bus.load_val[i*BCD_W +: BCD_W]))
                load_ok = 1'b0;
        end
    end

    always_comb begin
        action = ACT_HOLD;
        if (bus.load)
            action = load_ok ? ACT_LOAD : ACT_REJECT;
        else if (bus.en)
            action = ACT_STEP;
    end

    // A full chain marks the end of the range; saturation keeps the count there instead of wrapping
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        err_d   = 1'b0;
        unique case (action)
            ACT_LOAD:   count_d = bus.load_val;
            ACT_REJECT: err_d   = 1'b1;
            ACT_STEP: begin
                ovf_d = bus.up & max_chain[DIGITS];
                unf_d = ~bus.up & min_chain[DIGITS];
                if (!(SATURATE && (ovf_d || unf_d)))
                    count_d = stepped;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            err_q   <= err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;
    assign bus.load_err = err_q;
    assign bus.is_zero  = (count_q == '0);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: table of directed vectors on 3-digit wrap and saturate
// instances, then long up/down runs on 1-, 3- and 4-digit instances against a decimal model.
module tb_bcd_updown_counter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bcd_updown_counter_if #(.DIGITS(3)) bus3  ();
    bcd_updown_counter_if #(.DIGITS(3)) bus3s ();
    bcd_updown_counter_if #(.DIGITS(1)) bus1  ();
    bcd_updown_counter_if #(.DIGITS(4)) bus4  ();

    bcd_updown_counter #(.DIGITS(3), .SATURATE(1'b0)) dut3  (.clk(clk), .reset(reset), .bus(bus3.slave));
    bcd_updown_counter #(.DIGITS(3), .SATURATE(1'b1)) dut3s (.clk(clk), .reset(reset), .bus(bus3s.slave));
    bcd_updown_counter #(.DIGITS(1), .SATURATE(1'b0)) dut1  (.clk(clk), .reset(reset), .bus(bus1.slave));
    bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) dut4  (.clk(clk), .reset(reset), .bus(bus4.slave));

    typedef struct {
        string       name;
        logic        rst, en, up, load;
        logic [11:0] load_val;
        logic [11:0] count;
        logic [11:0] count_sat;
        logic        ovf, unf, load_err;
    } vec_t;

    typedef struct {
        int          id;
        string       name;
        logic [15:0] count;
        logic        ovf, unf, load_err, is_zero;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   model[3];
    int   ovf_seen[3];
    int   unf_seen[3];

    localparam int DIG[3] = '{1, 3, 4};
    localparam int MODV[3] = '{10, 1000, 10000};
    localparam int BUS_ID[3] = '{2, 0, 3};

    function automatic vec_t mk(string n, logic r, logic e, logic u, logic l, logic [11:0] lv,
                                logic [11:0] c, logic [11:0] cs, logic o, logic un, logic le);
        vec_t v;
        v.name = n; v.rst = r; v.en = e; v.up = u; v.load = l; v.load_val = lv;
        v.count = c; v.count_sat = cs; v.ovf = o; v.unf = un; v.load_err = le;
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(int value);
        logic [15:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic push_exp(int id, string name, logic [15:0] c, logic o, logic u, logic e);
        exp_t x;
        x.id = id; x.name = name; x.count = c;
        x.ovf = o; x.unf = u; x.load_err = e; x.is_zero = (c == 16'h0);
        sb.push_back(x);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [19:0] act;
        logic [19:0] want;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.id)
                0:       act = {4'h0,  bus3.count,  bus3.ovf,  bus3.unf,  bus3.load_err,  bus3.is_zero};
                1:       act = {4'h0,  bus3s.count, bus3s.ovf, bus3s.unf, bus3s.load_err, bus3s.is_zero};
                2:       act = {12'h0, bus1.count,  bus1.ovf,  bus1.unf,  bus1.load_err,  bus1.is_zero};
                default: act = {bus4.count, bus4.ovf, bus4.unf, bus4.load_err, bus4.is_zero};
            endcase
            want = {e.count, e.ovf, e.unf, e.load_err, e.is_zero};
            checks++;
            if (act !== want) begin
                errors++;
                $display("[TB] FAIL %s dut%0d: got count=%h ovf/unf/err/zero=%b, expected count=%h ovf/unf/err/zero=%b",
                         e.name, e.id, act[19:4], act[3:0], want[19:4], want[3:0]);
            end
        end
    endtask

    task automatic idle_small();
        bus1.en = 1'b0; bus1.up = 1'b0; bus1.load = 1'b0; bus1.load_val = '0;
        bus4.en = 1'b0; bus4.up = 1'b0; bus4.load = 1'b0; bus4.load_val = '0;
    endtask

    task automatic applyStimulus(vec_t v);
        @(negedge clk);
        reset = v.rst;
        bus3.en  = v.en; bus3.up  = v.up; bus3.load  = v.load; bus3.load_val  = v.load_val;
        bus3s.en = v.en; bus3s.up = v.up; bus3s.load = v.load; bus3s.load_val = v.load_val;
        push_exp(0, v.name, {4'h0, v.count},     v.ovf, v.unf, v.load_err);
        push_exp(1, v.name, {4'h0, v.count_sat}, v.ovf, v.unf, v.load_err);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // One cycle of counting on the 1-, 3- and 4-digit instances, expectations from integer arithmetic
    task automatic run_step(logic rst, logic dir, string tag);
        logic o, u;
        @(negedge clk);
        reset = rst;
        bus1.en = 1'b1; bus1.up = dir; bus1.load = 1'b0;
        bus3.en = 1'b1; bus3.up = dir; bus3.load = 1'b0;
        bus4.en = 1'b1; bus4.up = dir; bus4.load = 1'b0;
        bus3s.en = 1'b0; bus3s.load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            o = 1'b0;
            u = 1'b0;
            if (rst) begin
                model[k] = 0;
            end else if (dir) begin
                o = (model[k] == MODV[k] - 1);
                model[k] = (model[k] + 1) % MODV[k];
            end else begin
                u = (model[k] == 0);
                model[k] = (model[k] == 0) ? MODV[k] - 1 : model[k] - 1;
            end
            push_exp(BUS_ID[k], $sformatf("%s_d%0d", tag, DIG[k]), to_bcd(model[k]), o, u, 1'b0);
        end
        @(posedge clk);
        #1;
        if (bus1.ovf) ovf_seen[0]++;
        if (bus3.ovf) ovf_seen[1]++;
        if (bus4.ovf) ovf_seen[2]++;
        if (bus1.unf) unf_seen[0]++;
        if (bus3.unf) unf_seen[1]++;
        if (bus4.unf) unf_seen[2]++;
        checkOutput();
    endtask

    task automatic check_total(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus3.en = 1'b0; bus3.up = 1'b0; bus3.load = 1'b0; bus3.load_val = '0;
        bus3s.en = 1'b0; bus3s.up = 1'b0; bus3s.load = 1'b0; bus3s.load_val = '0;
        idle_small();

        vecs.push_back(mk("rst0",      1, 1, 1, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(mk("rst1",      1, 1, 1, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(mk("ld129",     0, 0, 0, 1, 12'h129, 12'h129, 12'h129, 0, 0, 0));
        vecs.push_back(mk("inc130",    0, 1, 1, 0, 12'h000, 12'h130, 12'h130, 0, 0, 0));
        vecs.push_back(mk("ld099",     0, 0, 0, 1, 12'h099, 12'h099, 12'h099, 0, 0, 0));
        vecs.push_back(mk("inc100",    0, 1, 1, 0, 12'h000, 12'h100, 12'h100, 0, 0, 0));
        vecs.push_back(mk("ld999",     0, 0, 0, 1, 12'h999, 12'h999, 12'h999, 0, 0, 0));
        vecs.push_back(mk("inc_top",   0, 1, 1, 0, 12'h000, 12'h000, 12'h999, 1, 0, 0));
        vecs.push_back(mk("hold_a",    0, 0, 1, 0, 12'h000, 12'h000, 12'h999, 0, 0, 0));
        vecs.push_back(mk("ld100",     0, 0, 0, 1, 12'h100, 12'h100, 12'h100, 0, 0, 0));
        vecs.push_back(mk("dec099",    0, 1, 0, 0, 12'h000, 12'h099, 12'h099, 0, 0, 0));
        vecs.push_back(mk("ld000",     0, 0, 0, 1, 12'h000, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(mk("dec_bot",   0, 1, 0, 0, 12'h000, 12'h999, 12'h000, 0, 1, 0));
        vecs.push_back(mk("hold_b",    0, 0, 0, 0, 12'h000, 12'h999, 12'h000, 0, 0, 0));
        vecs.push_back(mk("ld1A3",     0, 0, 0, 1, 12'h1A3, 12'h999, 12'h000, 0, 0, 1));
        vecs.push_back(mk("hold_c",    0, 0, 0, 0, 12'h000, 12'h999, 12'h000, 0, 0, 0));
        vecs.push_back(mk("ld_en456",  0, 1, 1, 1, 12'h456, 12'h456, 12'h456, 0, 0, 0));
        vecs.push_back(mk("dec455",    0, 1, 0, 0, 12'h000, 12'h455, 12'h455, 0, 0, 0));
        vecs.push_back(mk("rst_ld",    1, 1, 1, 1, 12'h777, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(mk("inc001",    0, 1, 1, 0, 12'h000, 12'h001, 12'h001, 0, 0, 0));
        vecs.push_back(mk("dec000",    0, 1, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(mk("ld9A9",     0, 0, 0, 1, 12'h9A9, 12'h000, 12'h000, 0, 0, 1));
        vecs.push_back(mk("ld058",     0, 0, 0, 1, 12'h058, 12'h058, 12'h058, 0, 0, 0));
        vecs.push_back(mk("rst_mid",   1, 1, 1, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0));
        vecs.push_back(mk("ld199",     0, 0, 0, 1, 12'h199, 12'h199, 12'h199, 0, 0, 0));
        vecs.push_back(mk("inc200",    0, 1, 1, 0, 12'h000, 12'h200, 12'h200, 0, 0, 0));
        vecs.push_back(mk("dec199",    0, 1, 0, 0, 12'h000, 12'h199, 12'h199, 0, 0, 0));
        vecs.push_back(mk("ld090",     0, 0, 0, 1, 12'h090, 12'h090, 12'h090, 0, 0, 0));
        vecs.push_back(mk("dec089",    0, 1, 0, 0, 12'h000, 12'h089, 12'h089, 0, 0, 0));
        vecs.push_back(mk("ld_en999",  0, 1, 1, 1, 12'h999, 12'h999, 12'h999, 0, 0, 0));
        vecs.push_back(mk("inc_top2",  0, 1, 1, 0, 12'h000, 12'h000, 12'h999, 1, 0, 0));
        vecs.push_back(mk("ldbad_en",  0, 1, 1, 1, 12'hF00, 12'h000, 12'h999, 0, 0, 1));
        vecs.push_back(mk("hold_d",    0, 0, 1, 0, 12'h000, 12'h000, 12'h999, 0, 0, 0));

        foreach (vecs[i]) applyStimulus(vecs[i]);

        for (int k = 0; k < 3; k++) begin
            model[k] = 0;
            ovf_seen[k] = 0;
            unf_seen[k] = 0;
        end
        run_step(1'b1, 1'b1, "fr_rst");
        for (int n = 0; n < 10000; n++) run_step(1'b0, 1'b1, "fr_up");
        check_total("ovf_total_d1", ovf_seen[0], 1000);
        check_total("ovf_total_d3", ovf_seen[1], 10);
        check_total("ovf_total_d4", ovf_seen[2], 1);

        for (int n = 0; n < 1100; n++) run_step(1'b0, 1'b0, "fr_dn");
        check_total("unf_total_d1", unf_seen[0], 110);
        check_total("unf_total_d3", unf_seen[1], 2);
        check_total("unf_total_d4", unf_seen[2], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
